// File: rtl/rshift_arbiter.sv
// Two-requester arbiter sharing one right shifter (fill bit + sticky) into a registered result slot.
// Optional build macro RSHIFT_ARB_RR_EN selects round-robin grant; default is fixed priority to requester 0.

module rshift_arbiter_shifter #(
  parameter int n = 32,
  parameter int s = 5
) (
  input  logic [n-1:0] data_i,
  input  logic [s-1:0] amt_i,
  input  logic         sgn_i,
  output logic [n-1:0] data_o,
  output logic         sticky_o
);
  logic [31:0]    amt_w;
  logic [31:0]    amt_c;
  logic [2*n-1:0] ext;
  logic [n-1:0]   fill_mask;

  always_comb begin
    amt_w = 32'(amt_i);
    amt_c = (amt_w >= 32'(n)) ? 32'(n) : amt_w;
    // Lower half of ext collects exactly the bits shifted out of data.
    ext       = {data_i, {n{1'b0}}} >> amt_c;
    fill_mask = ~({n{1'b1}} >> amt_c);
    data_o    = ext[2*n-1:n] | (sgn_i ? fill_mask : '0);
    sticky_o  = |ext[n-1:0];
  end
endmodule

module rshift_arbiter #(
  parameter int n = 32,
  parameter int s = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [n-1:0] req0_data,
  input  logic [s-1:0] req0_amt,
  input  logic         req0_sgn,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [n-1:0] req1_data,
  input  logic [s-1:0] req1_amt,
  input  logic         req1_sgn,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_data,
  output logic         out_sticky,
  output logic         out_id
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t       state_q;
  logic [n-1:0] data_q;
  logic         sticky_q;
  logic         id_q;

  logic         free;
  logic         accept;
  logic         grant1;
  logic         prefer1;
  logic [n-1:0] sel_data;
  logic [s-1:0] sel_amt;
  logic         sel_sgn;
  logic [n-1:0] shf_data;
  logic         shf_sticky;

`ifdef RSHIFT_ARB_RR_EN
  // ptr_q names the requester that wins a tie; it flips away from each granted requester.
  logic ptr_q;
  assign prefer1 = ptr_q;
`else
  assign prefer1 = 1'b0;
`endif

  always_comb begin
    free       = (state_q == EMPTY) || out_ready;
    grant1     = req1_valid && (!req0_valid || prefer1);
    accept     = free && !reset && (req0_valid || req1_valid);
    req0_ready = accept && !grant1;
    req1_ready = accept && grant1;
    sel_data   = grant1 ? req1_data : req0_data;
    sel_amt    = grant1 ? req1_amt  : req0_amt;
    sel_sgn    = grant1 ? req1_sgn  : req0_sgn;
  end

  rshift_arbiter_shifter #(.n(n), .s(s)) u_shifter (
    .data_i   (sel_data),
    .amt_i    (sel_amt),
    .sgn_i    (sel_sgn),
    .data_o   (shf_data),
    .sticky_o (shf_sticky)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      sticky_q <= 1'b0;
      id_q     <= 1'b0;
`ifdef RSHIFT_ARB_RR_EN
      ptr_q    <= 1'b0;
`endif
    end else if (accept) begin
      state_q  <= FULL;
      data_q   <= shf_data;
      sticky_q <= shf_sticky;
      id_q     <= grant1;
`ifdef RSHIFT_ARB_RR_EN
      ptr_q    <= ~grant1;
`endif
    end else if (free) begin
      state_q  <= EMPTY;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_data   = data_q;
  assign out_sticky = sticky_q;
  assign out_id     = id_q;
endmodule

// File: tb/tb_rshift_arbiter.sv
// Self-checking bench for rshift_arbiter (n=8, s=3): directed vectors plus randomized traffic vs a reference model.
`timescale 1ns/1ps

module tb_rshift_arbiter;
  localparam int N = 8;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req0_sgn;
  logic [N-1:0] req0_data;
  logic [S-1:0] req0_amt;
  logic         req1_valid, req1_ready, req1_sgn;
  logic [N-1:0] req1_data;
  logic [S-1:0] req1_amt;
  logic         out_valid, out_ready, out_sticky, out_id;
  logic [N-1:0] out_data;

  int checks = 0;
  int passed = 0;

  rshift_arbiter #(.n(N), .s(S)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_sgn(req0_sgn),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_sgn(req1_sgn),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sticky(out_sticky), .out_id(out_id)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

`ifdef RSHIFT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Reference: bit i of the result is source bit i+amt, or the fill bit past the MSB.
  function automatic logic [N:0] ref_shift(input logic [N-1:0] d, input int amt, input logic sg);
    logic [N-1:0] r;
    logic st;
    st = 1'b0;
    for (int i = 0; i < N; i++) begin
      r[i] = (i + amt < N) ? d[(i + amt) % N] : sg;
      if (i < amt) st = st | d[i];
    end
    return {st, r};
  endfunction

  task automatic idle_inputs();
    req0_valid = 0; req0_data = '0; req0_amt = '0; req0_sgn = 0;
    req1_valid = 0; req1_data = '0; req1_amt = '0; req1_sgn = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1; reset = 1;
    req0_valid = 1; req1_valid = 1; req0_data = 8'hFF;
    tick();
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL reset_ready: got %b%b required 00", req0_ready, req1_ready); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", out_valid); else passed++;
    checks++; if ({out_data, out_sticky, out_id} !== 10'd0) $display("FAIL reset_out: got data=%h st=%b id=%b required 0", out_data, out_sticky, out_id); else passed++;
    reset = 0; idle_inputs();
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL idle_valid: got %b required 0", out_valid); else passed++;
  endtask

  task automatic test_vectors();
    logic [N-1:0] vd [4] = '{8'hB4, 8'hB4, 8'h80, 8'h80};
    int           va [4] = '{3, 3, 7, 0};
    logic         vs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic         vr [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [N-1:0] ed [4] = '{8'h16, 8'hF6, 8'h01, 8'h80};
    logic         es [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      idle_inputs();
      if (vr[k]) begin
        req1_valid = 1; req1_data = vd[k]; req1_amt = S'(va[k]); req1_sgn = vs[k];
      end else begin
        req0_valid = 1; req0_data = vd[k]; req0_amt = S'(va[k]); req0_sgn = vs[k];
      end
      #1;
      checks++; if ({req1_ready, req0_ready} !== (vr[k] ? 2'b10 : 2'b01)) $display("FAIL vec%0d_ready: got %b%b", k, req1_ready, req0_ready); else passed++;
      tick();
      idle_inputs();
      checks++; if (out_valid !== 1'b1 || out_data !== ed[k] || out_sticky !== es[k] || out_id !== vr[k])
        $display("FAIL vec%0d_out: got v=%b d=%h st=%b id=%b required v=1 d=%h st=%b id=%b", k, out_valid, out_data, out_sticky, out_id, ed[k], es[k], vr[k]);
      else passed++;
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL vec%0d_drain: got %b required 0", k, out_valid); else passed++;
    end
  endtask

  task automatic test_arbitration();
    logic exp_id;
    out_ready = 1;
    idle_inputs();
    req0_valid = 1; req0_data = 8'h11; req0_amt = 3'd1;
    req1_valid = 1; req1_data = 8'h22; req1_amt = 3'd2;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_id = RR ? ((k % 2) == 1) : 1'b0;
      checks++; if (out_valid !== 1'b1 || out_id !== exp_id) $display("FAIL arb%0d_id: got v=%b id=%b required v=1 id=%b", k, out_valid, out_id, exp_id); else passed++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    logic [N:0] ea, eb;
    ea = ref_shift(8'h5A, 2, 1'b1);
    eb = ref_shift(8'hC3, 5, 1'b0);
    idle_inputs(); out_ready = 1;
    req0_valid = 1; req0_data = 8'h5A; req0_amt = 3'd2; req0_sgn = 1;
    tick();
    req0_valid = 0; out_ready = 0;
    req1_valid = 1; req1_data = 8'hC3; req1_amt = 3'd5; req1_sgn = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL bp%0d_ready: got %b%b required 00", k, req0_ready, req1_ready); else passed++;
      checks++; if (out_valid !== 1'b1 || {out_sticky, out_data} !== ea || out_id !== 1'b0)
        $display("FAIL bp%0d_hold: got v=%b st/d=%h id=%b required v=1 st/d=%h id=0", k, out_valid, {out_sticky, out_data}, out_id, ea);
      else passed++;
      tick();
    end
    out_ready = 1; #1;
    checks++; if (req1_ready !== 1'b1) $display("FAIL bp_accept: got %b required 1", req1_ready); else passed++;
    tick();
    idle_inputs();
    checks++; if (out_valid !== 1'b1 || {out_sticky, out_data} !== eb || out_id !== 1'b1)
      $display("FAIL bp_next: got v=%b st/d=%h id=%b required v=1 st/d=%h id=1", out_valid, {out_sticky, out_data}, out_id, eb);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs(); out_ready = 1;
    req0_valid = 1; req0_data = 8'hE7; req0_amt = 3'd4;
    tick();
    out_ready = 0; reset = 1; req1_valid = 1; req1_data = 8'h3C;
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL rstmid_ready: got %b%b required 00", req0_ready, req1_ready); else passed++;
    tick();
    reset = 0; idle_inputs(); out_ready = 1;
    checks++; if (out_valid !== 1'b0 || {out_data, out_sticky, out_id} !== 10'd0)
      $display("FAIL rstmid_out: got v=%b d=%h st=%b id=%b required all 0", out_valid, out_data, out_sticky, out_id);
    else passed++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_after: got %b required 0", out_valid); else passed++;
  endtask

  task automatic test_random();
    bit           p0 = 0, p1 = 0, m_valid = 0, m_pref1 = 0, m_id = 0, free, g1, e0, e1;
    logic [N-1:0] d0, d1, m_data;
    logic [N:0]   r;
    int           a0, a1;
    bit           s0, s1, m_st;
    reset = 1; idle_inputs(); out_ready = 1;
    tick();
    reset = 0;
    m_data = '0; m_st = 0; d0 = '0; d1 = '0; a0 = 0; a1 = 0; s0 = 0; s1 = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin p0 = 1; d0 = N'($urandom); a0 = $urandom_range(0, 7); s0 = 1'($urandom); end
      if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1; d1 = N'($urandom); a1 = $urandom_range(0, 7); s1 = 1'($urandom); end
      req0_valid = p0; req0_data = d0; req0_amt = S'(a0); req0_sgn = s0;
      req1_valid = p1; req1_data = d1; req1_amt = S'(a1); req1_sgn = s1;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      free = !m_valid || out_ready;
      g1 = p1 && (!p0 || (RR && m_pref1));
      e0 = free && p0 && !g1;
      e1 = free && p1 && g1;
      checks++; if (req0_ready !== e0 || req1_ready !== e1) $display("FAIL rnd%0d_ready: got %b%b required %b%b", cyc, req0_ready, req1_ready, e0, e1); else passed++;
      tick();
      if (e0 || e1) begin
        r = g1 ? ref_shift(d1, a1, s1) : ref_shift(d0, a0, s0);
        m_valid = 1; m_data = r[N-1:0]; m_st = r[N]; m_id = g1; m_pref1 = !g1;
        if (g1) p1 = 0; else p0 = 0;
      end else if (free) begin
        m_valid = 0;
      end
      checks++; if (out_valid !== m_valid) $display("FAIL rnd%0d_valid: got %b required %b", cyc, out_valid, m_valid); else passed++;
      if (m_valid) begin
        checks++; if (out_data !== m_data || out_sticky !== m_st || out_id !== m_id)
          $display("FAIL rnd%0d_out: got d=%h st=%b id=%b required d=%h st=%b id=%b", cyc, out_data, out_sticky, out_id, m_data, m_st, m_id);
        else passed++;
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    reset = 1; out_ready = 1;
    idle_inputs();
    test_reset();
    test_vectors();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
